rf_port_arbiter: RTL and testbench

Shares the register file's write port and read port 1 between the pipeline core and a debug/host requester. It sits between the pipeline's register-file port signals and the register file itself. The core normally has priority. A pending debug access that has waited MAX_WAIT cycles steals the port for one cycle by stalling the pipeline. Debug accesses use a four-phase req/ack handshake.

---
 rtl/rf_port_arbiter_pkg.sv | 23 ++
 rtl/rf_port_arbiter_mux.sv | 48 ++++
 rtl/rf_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_rf_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_port_arbiter_pkg.sv
// Shared types and constants for the register-file port arbiter.
// Holds the FSM state encoding, the register-index/data widths and the
// latched debug request payload.
package rf_port_arbiter_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        STEAL   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Debug request captured in IDLE and held for the whole transaction
    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] wdata;
    } dbg_req_t;

endpackage

// File: rtl/rf_port_arbiter_mux.sv
// Combinational steering of the register-file write port and read ports.
// Ports:
//   act, steal          - debug access this cycle / forced-steal cycle
//   req                 - latched debug request
//   core_*              - pipeline register-file port signals
//   rf_*                - signals driven to the register file
module rf_port_mux
    import rf_port_arbiter_pkg::*;
(
    input  logic              act,
    input  logic              steal,
    input  dbg_req_t          req,
    input  logic              core_we,
    input  logic [REG_W-1:0]  core_wreg,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [REG_W-1:0]  core_rreg1,
    input  logic [REG_W-1:0]  core_rreg2,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_wreg,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [REG_W-1:0]  rf_rreg1,
    output logic [REG_W-1:0]  rf_rreg2
);

    // Core owns both ports unless a debug access is in progress; a debug
    // read only takes read port 1, a debug write only takes the write port.
    always_comb begin
        rf_we    = core_we;
        rf_wreg  = core_wreg;
        rf_wdata = core_wdata;
        rf_rreg1 = core_rreg1;
        rf_rreg2 = core_rreg2;
        if (act) begin
            if (req.we) begin
                rf_we    = 1'b1;
                rf_wreg  = req.addr;
                rf_wdata = req.wdata;
            end else begin
                rf_rreg1 = req.addr;
                // Pipeline is frozen during a steal; its write replays next cycle
                if (steal) begin
                    rf_we = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Arbitrates the register-file write port and read port 1 between the
// pipeline core (priority) and a four-phase debug requester. A debug access
// that has waited MAX_WAIT cycles steals the port for one cycle by stalling
// the pipeline.
// Ports:
//   clk, reset                        - clock, async active-high reset
//   core_we/wreg/wdata, core_rreg1/2,
//   core_rd1_en                       - pipeline register-file port signals
//   core_stall                        - freeze the pipeline (steal cycle)
//   dbg_req/we/addr/wdata             - debug request
//   dbg_ack, dbg_rdata                - debug completion and read data
//   rf_*                              - register-file port signals
//   steal_count                       - saturating count of forced steals
module rf_port_arbiter
    import rf_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_we,
    input  logic [REG_W-1:0]  core_wreg,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [REG_W-1:0]  core_rreg1,
    input  logic              core_rd1_en,
    input  logic [REG_W-1:0]  core_rreg2,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [REG_W-1:0]  dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_wreg,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [REG_W-1:0]  rf_rreg1,
    output logic [REG_W-1:0]  rf_rreg2,
    input  logic [DATA_W-1:0] rf_rdata1,
    output logic [CNT_W-1:0]  steal_count
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           state_q;
    state_t           state_d;
    dbg_req_t         req_q;
    logic [CNT_W-1:0] wait_q;
    logic             conflict_c;
    logic             act_c;
    logic             steal_c;

    // A write conflicts with the core's write, a read with the core's read 1
    assign conflict_c = req_q.we ? core_we : core_rd1_en;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dbg_req) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (!conflict_c) begin
                    state_d = DONE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = STEAL;
                end
            end
            STEAL: state_d = DONE;
            DONE: begin
                if (!dbg_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoded access strobes
    always_comb begin
        steal_c = (state_q == STEAL);
        act_c   = ((state_q == PENDING) && !conflict_c) || steal_c;
    end

    // Request latch, wait counter, steal counter and handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q       <= '0;
            wait_q      <= '0;
            steal_count <= '0;
            core_stall  <= 1'b0;
            dbg_ack     <= 1'b0;
            dbg_rdata   <= '0;
        end else begin
            // Registered from the next state so they line up with STEAL/DONE
            core_stall <= (state_d == STEAL);
            dbg_ack    <= (state_d == DONE);
            if ((state_q == IDLE) && dbg_req) begin
                req_q  <= '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
                wait_q <= '0;
            end else if ((state_q == PENDING) && conflict_c && (wait_q != WAIT_LAST)) begin
                wait_q <= wait_q + CNT_W'(1);
            end
            if (steal_c && (steal_count != '1)) begin
                steal_count <= steal_count + CNT_W'(1);
            end
            // r0 always reads as zero regardless of what the file returns
            if (act_c && !req_q.we) begin
                dbg_rdata <= (req_q.addr == '0) ? '0 : rf_rdata1;
            end
        end
    end

    rf_port_mux u_mux (
        .act        (act_c),
        .steal      (steal_c),
        .req        (req_q),
        .core_we    (core_we),
        .core_wreg  (core_wreg),
        .core_wdata (core_wdata),
        .core_rreg1 (core_rreg1),
        .core_rreg2 (core_rreg2),
        .rf_we      (rf_we),
        .rf_wreg    (rf_wreg),
        .rf_wdata   (rf_wdata),
        .rf_rreg1   (rf_rreg1),
        .rf_rreg2   (rf_rreg2)
    );

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural register file.
module tb_rf_port_arbiter;

    logic        clk;
    logic        reset;
    logic        core_we;
    logic [4:0]  core_wreg;
    logic [31:0] core_wdata;
    logic [4:0]  core_rreg1;
    logic        core_rd1_en;
    logic [4:0]  core_rreg2;
    logic        core_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        rf_we;
    logic [4:0]  rf_wreg;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_rreg1;
    logic [4:0]  rf_rreg2;
    logic [31:0] rf_rdata1;
    logic [7:0]  steal_count;

    int n_chk;
    int n_pass;

    rf_port_arbiter #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_we     (core_we),
        .core_wreg   (core_wreg),
        .core_wdata  (core_wdata),
        .core_rreg1  (core_rreg1),
        .core_rd1_en (core_rd1_en),
        .core_rreg2  (core_rreg2),
        .core_stall  (core_stall),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .rf_we       (rf_we),
        .rf_wreg     (rf_wreg),
        .rf_wdata    (rf_wdata),
        .rf_rreg1    (rf_rreg1),
        .rf_rreg2    (rf_rreg2),
        .rf_rdata1   (rf_rdata1),
        .steal_count (steal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: r0 hard-wired to zero
    logic [31:0] regs [32];
    logic        rf_load;

    always_ff @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'(i) * 32'h0101_0101;
        end else if (rf_we && (rf_wreg != 5'd0)) begin
            regs[rf_wreg] <= rf_wdata;
        end
    end
    assign rf_rdata1 = regs[rf_rreg1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        core_we     = 1'b0;
        core_wreg   = 5'd0;
        core_wdata  = 32'd0;
        core_rreg1  = 5'd0;
        core_rd1_en = 1'b0;
        core_rreg2  = 5'd0;
    endtask

    task automatic dbg_start(input logic we, input logic [4:0] addr, input logic [31:0] wdata);
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  rreg1;
        logic        rd1_en;
        logic [4:0]  rreg2;
        logic        exp_we;
        logic [4:0]  exp_wreg;
        logic [31:0] exp_wdata;
        logic [4:0]  exp_rreg1;
        logic [4:0]  exp_rreg2;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;

        vecs[0] = '{1'b0, 5'd20, 32'h0000_0000, 5'd1,  1'b0, 5'd2,  1'b0, 5'd20, 32'h0000_0000, 5'd1,  5'd2};
        vecs[1] = '{1'b1, 5'd21, 32'hCAFE_F00D, 5'd31, 1'b1, 5'd30, 1'b1, 5'd21, 32'hCAFE_F00D, 5'd31, 5'd30};
        vecs[2] = '{1'b1, 5'd22, 32'h8000_0001, 5'd0,  1'b0, 5'd17, 1'b1, 5'd22, 32'h8000_0001, 5'd0,  5'd17};
        vecs[3] = '{1'b0, 5'd23, 32'hFFFF_FFFF, 5'd15, 1'b1, 5'd16, 1'b0, 5'd23, 32'hFFFF_FFFF, 5'd15, 5'd16};

        // Reset state
        reset   = 1'b1;
        rf_load = 1'b1;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
        core_idle();
        tick();
        tick();
        check("reset_core_stall", 32'(core_stall), 32'd0);
        check("reset_dbg_ack", 32'(dbg_ack), 32'd0);
        check("reset_dbg_rdata", dbg_rdata, 32'd0);
        check("reset_steal_count", 32'(steal_count), 32'd0);
        reset   = 1'b0;
        rf_load = 1'b0;
        tick();

        // Pass-through with no debug activity
        for (int i = 0; i < 4; i++) begin
            core_we = vecs[i].we; core_wreg = vecs[i].wreg; core_wdata = vecs[i].wdata;
            core_rreg1 = vecs[i].rreg1; core_rd1_en = vecs[i].rd1_en; core_rreg2 = vecs[i].rreg2;
            #1;
            check($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_rf_wreg", i), 32'(rf_wreg), 32'(vecs[i].exp_wreg));
            check($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
            check($sformatf("vec%0d_rf_rreg1", i), 32'(rf_rreg1), 32'(vecs[i].exp_rreg1));
            check($sformatf("vec%0d_rf_rreg2", i), 32'(rf_rreg2), 32'(vecs[i].exp_rreg2));
            check($sformatf("vec%0d_stall", i), 32'(core_stall), 32'd0);
            tick();
        end
        core_idle();
        tick();

        // Debug write, idle core
        dbg_start(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        #1;
        check("wr_idle_rf_we", 32'(rf_we), 32'd1);
        check("wr_idle_rf_wreg", 32'(rf_wreg), 32'd5);
        check("wr_idle_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("wr_idle_stall", 32'(core_stall), 32'd0);
        check("wr_idle_ack_early", 32'(dbg_ack), 32'd0);
        tick();
        check("wr_idle_ack", 32'(dbg_ack), 32'd1);
        check("wr_idle_stall2", 32'(core_stall), 32'd0);
        check("wr_idle_r5", regs[5], 32'hDEAD_BEEF);
        dbg_req = 1'b0;
        tick();
        check("wr_idle_ack_drop", 32'(dbg_ack), 32'd0);

        // Debug read with core write in parallel
        core_we = 1'b1; core_wreg = 5'd7; core_wdata = 32'h1234_5678;
        tick();
        core_wreg = 5'd9; core_wdata = 32'hA5A5_A5A5;
        dbg_start(1'b0, 5'd7, 32'd0);
        tick();
        #1;
        check("rd_par_rf_rreg1", 32'(rf_rreg1), 32'd7);
        check("rd_par_rf_we", 32'(rf_we), 32'd1);
        check("rd_par_rf_wreg", 32'(rf_wreg), 32'd9);
        check("rd_par_stall", 32'(core_stall), 32'd0);
        tick();
        check("rd_par_ack", 32'(dbg_ack), 32'd1);
        check("rd_par_rdata", dbg_rdata, 32'h1234_5678);
        check("rd_par_r9", regs[9], 32'hA5A5_A5A5);
        dbg_req = 1'b0;
        core_idle();
        tick();

        // Forced steal of the write port, then hold req after ack
        core_we = 1'b1; core_wreg = 5'd10; core_wdata = 32'h0000_1010;
        dbg_start(1'b1, 5'd3, 32'h0000_0055);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("steal_pend%0d_stall", i), 32'(core_stall), 32'd0);
            check($sformatf("steal_pend%0d_rf_wreg", i), 32'(rf_wreg), 32'd10);
            tick();
        end
        #1;
        check("steal_stall", 32'(core_stall), 32'd1);
        check("steal_rf_we", 32'(rf_we), 32'd1);
        check("steal_rf_wreg", 32'(rf_wreg), 32'd3);
        check("steal_rf_wdata", rf_wdata, 32'h0000_0055);
        check("steal_ack_early", 32'(dbg_ack), 32'd0);
        tick();
        check("steal_ack", 32'(dbg_ack), 32'd1);
        check("steal_stall_drop", 32'(core_stall), 32'd0);
        check("steal_count1", 32'(steal_count), 32'd1);
        check("steal_r3", regs[3], 32'h0000_0055);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d_ack", i), 32'(dbg_ack), 32'd1);
            check($sformatf("hold%0d_rf_wreg", i), 32'(rf_wreg), 32'd10);
            check($sformatf("hold%0d_stall", i), 32'(core_stall), 32'd0);
        end
        dbg_req = 1'b0;
        tick();
        check("hold_ack_drop", 32'(dbg_ack), 32'd0);
        check("hold_steal_count", 32'(steal_count), 32'd1);
        core_idle();
        tick();

        // Register 0: write is discarded, read returns zero
        dbg_start(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        tick();
        check("r0_wr_ack", 32'(dbg_ack), 32'd1);
        dbg_req = 1'b0;
        tick();
        dbg_start(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        check("r0_rd_ack", 32'(dbg_ack), 32'd1);
        check("r0_rd_rdata", dbg_rdata, 32'd0);
        dbg_req = 1'b0;
        tick();

        // Reset while PENDING with wait counter at 2
        core_we = 1'b1; core_wreg = 5'd10; core_wdata = 32'h0000_2020;
        dbg_start(1'b1, 5'd3, 32'h0000_0BAD);
        tick();
        tick();
        tick();
        reset   = 1'b1;
        dbg_req = 1'b0;
        #1;
        check("rst_mid_stall", 32'(core_stall), 32'd0);
        check("rst_mid_ack", 32'(dbg_ack), 32'd0);
        check("rst_mid_steal_count", 32'(steal_count), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("rst_mid_r3", regs[3], 32'h0000_0055);
        check("rst_mid_ack_after", 32'(dbg_ack), 32'd0);
        core_idle();
        tick();

        // Debug write alongside a core read
        core_rd1_en = 1'b1; core_rreg1 = 5'd7;
        dbg_start(1'b1, 5'd12, 32'hC0FF_EE00);
        tick();
        #1;
        check("wr_par_rf_rreg1", 32'(rf_rreg1), 32'd7);
        check("wr_par_rf_we", 32'(rf_we), 32'd1);
        check("wr_par_rf_wreg", 32'(rf_wreg), 32'd12);
        check("wr_par_stall", 32'(core_stall), 32'd0);
        tick();
        check("wr_par_r12", regs[12], 32'hC0FF_EE00);
        dbg_req = 1'b0;
        tick();

        // Forced steal of read port 1; core write suppressed in steal cycle
        core_we = 1'b1; core_wreg = 5'd13; core_wdata = 32'h1313_1313;
        dbg_start(1'b0, 5'd12, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("rdsteal_stall", 32'(core_stall), 32'd1);
        check("rdsteal_rf_rreg1", 32'(rf_rreg1), 32'd12);
        check("rdsteal_rf_we", 32'(rf_we), 32'd0);
        tick();
        check("rdsteal_ack", 32'(dbg_ack), 32'd1);
        check("rdsteal_rdata", dbg_rdata, 32'hC0FF_EE00);
        check("rdsteal_count", 32'(steal_count), 32'd1);
        dbg_req = 1'b0;
        core_idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
